sensor_cmd_decoder: RTL and testbench
=====================================

# sensor_cmd_decoder

Consumes the 16-bit two-byte frames produced by the serial receiver and turns them into sensor transactions and two-byte responses for the serial transmitter. It crosses the frame strobe from the baud clock into the system clock and decodes command and address. It then drives a request/done handshake to the sensor controller, applies a timeout, and optionally re-polls a sensor periodically (continuous mode).

## Interface
- `NUM_SENSORS`, 32: addresses `0..NUM_SENSORS-1` are valid (max 256).
- `TIMEOUT_CYCLES`, 1_000_000: `clk` cycles allowed for a sensor transaction.
- `PERIOD_CYCLES`, 50_000_000: continuous-mode poll interval in `clk` cycles.
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data`  in  16  frame from receiver; `[7:0]` = command byte, `[15:8]` = address byte; stable while `rx_recived` high.
- `rx_recived`  in  1  frame-valid level from receiver; baud-clock domain, asynchronous to `clk`.
- `sns_req`  out  1  sensor request, held until `sns_done` or timeout.
- `sns_addr`  out  8  sensor address, stable while `sns_req` high.
- `sns_done`  in  1  one-cycle completion pulse.
- `sns_ok`  in  1  sensor status, valid with `sns_done`.
- `sns_temp`, `sns_hum`  in  8 each  readings, valid with `sns_done`.
- `tx_valid`  out  1  response valid.
- `tx_data`  out  16  `[7:0]` = response code, `[15:8]` = value; stable while `tx_valid` high.
- `tx_ready`  in  1  transmitter accepts when `tx_valid && tx_ready`.
- `state_out`  out  2  FSM state for debug: IDLE=0, SENSOR=1, SEND=2.

## Operation
- `rx_recived` passes through a 2-flop synchronizer and a rising-edge detector. On the edge, `rx_data` is latched into a one-deep pending buffer.
- If a frame arrives while the buffer is full, the new frame is dropped.
- Commands:
  - 0x00: status.
  - 0x01: read temperature.
  - 0x02: read humidity.
  - 0x03 / 0x04: enable continuous temperature / humidity.
  - 0x05 / 0x06: disable continuous temperature / humidity.
- Address check: if the address is `>= NUM_SENSORS`, respond 0xE1 with value = address; no sensor access.
- Command check: any other command responds 0xE0 with value = command byte. Command validity is checked before the address.
- IDLE:
  - Pending command has priority over a due continuous poll.
  - Sensor commands go to SENSOR.
  - Disable commands clear the matching mode and go to SEND. Disable responses are 0x0A (temperature) and 0x0B (humidity), value = address; they are sent even if the mode was inactive.
  - Invalid commands go to SEND.
  - The pending buffer is freed on leaving IDLE.
- SENSOR:
  - `sns_req=1`; the timeout counter runs.
  - On `sns_done`:
    - If `!sns_ok`, respond 0x1F with value = address.
    - Status command: 0x07, value = address.
    - Temperature read: 0x09, value = `sns_temp`.
    - Humidity read: 0x08, value = `sns_hum`.
    - Continuous poll or enable: 0x0C, value = `sns_temp`, or 0x0D, value = `sns_hum`.
  - On timeout, respond 0x1F, value = address.
  - If `sns_done` and timeout occur in the same cycle, `sns_done` wins.
- SEND: hold `tx_valid` and `tx_data` until `tx_ready`, then return to IDLE.
- Continuous mode:
  - A single mode register holds off / temperature / humidity plus an address.
  - Enable replaces any prior mode, reloads the period timer and performs an immediate read.
  - On each timer expiry, `poll_due` is set. It is cleared when the poll starts or the mode is disabled.

## Timing
- Reset values: `sns_req=0`, `sns_addr=0`, `tx_valid=0`, `tx_data=0`, `state_out=0`. Pending buffer empty, mode off, both counters 0.
- Reset asserted mid-transaction drops `sns_req`/`tx_valid` immediately; no partial response after release.
- Frame latency:
  - `rx_recived` rising at `clk` edge N gives the pending buffer full at N+3.
  - The FSM leaves IDLE at N+4.
  - `sns_req`, or `tx_valid` for error responses, is high at N+4.
- SENSOR exits on the cycle after `sns_done`; `tx_valid` is high on that cycle.
- Timeout fires when the counter reaches `TIMEOUT_CYCLES-1` in SENSOR; the counter clears on entry.
- Period timer wraps at `PERIOD_CYCLES-1`.
- Back-to-back frames: one frame is queued during a transaction; a third is lost.

## Configuration
- `SENSOR_CMD_CONTINUOUS_EN` defined: continuous mode, period timer and commands 0x03–0x06 are implemented as above.
- Undefined:
  - No mode register or timer.
  - Commands 0x03–0x06 respond 0xE0 with value = command.
  - Codes 0x0A–0x0D are never produced.

## Test plan
- Frame 0x0501 (address 5, temperature); `sns_done` with `sns_ok=1`, `sns_temp=0x19` -> `tx_data=0x1909`; `sns_req` deasserted.
- Frame 0x0007 -> `tx_data=0x07E0`, no `sns_req`. Frame 0x2802 with `NUM_SENSORS=32` -> `tx_data=0x28E1`.
- Frame 0x0300 with no `sns_done` -> `sns_req` drops after `TIMEOUT_CYCLES`, `tx_data=0x031F`. Also: `sns_done` on the terminal cycle gives a normal response.
- Hold `tx_ready=0` and send three frames in a row -> first response held stable; second executed after handshake; third lost.
- Macro on, `PERIOD_CYCLES=100`:
  - Frame 0x0204 -> immediate 0x..0D, then 0x..0D every 100 cycles.
  - Frame 0x0206 -> 0x020B; polling stops.
  - Macro off: frame 0x0204 -> 0x04E0.
- Assert `rst_n=0` during SENSOR and during SEND -> outputs at reset values next edge; the next frame is processed normally.

Source files
------------

// File: rtl/sensor_cmd_decoder.sv
// Sensor command decoder: synchronises receiver frames, runs sensor request/done transactions, returns 2-byte responses.
// Define SENSOR_CMD_CONTINUOUS_EN to build continuous polling (mode register, period timer, commands 0x03-0x06).
module sensor_cmd_decoder #(
  parameter int unsigned NUM_SENSORS    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned PERIOD_CYCLES  = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] rx_data,
  input  logic        rx_recived,
  output logic        sns_req,
  output logic [7:0]  sns_addr,
  input  logic        sns_done,
  input  logic        sns_ok,
  input  logic [7:0]  sns_temp,
  input  logic [7:0]  sns_hum,
  output logic        tx_valid,
  output logic [15:0] tx_data,
  input  logic        tx_ready,
  output logic [1:0]  state_out
);
  localparam int unsigned   TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    ADDR_LIM = 9'(NUM_SENSORS);

  typedef enum logic [1:0] {IDLE = 2'd0, SENSOR = 2'd1, SEND = 2'd2} state_e;
  typedef enum logic [2:0] {OP_STATUS, OP_TEMP, OP_HUM, OP_CTEMP, OP_CHUM} op_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [7:0]    addr_q, addr_d;
  logic [15:0]   tx_q, tx_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    sync_q;
  logic          rise_q;
  logic          pend_vld_q, pend_vld_d;
  logic [15:0]   pend_q, pend_d;
  logic [7:0]    cmd, cadr;
  logic          cmd_ok, adr_ok;
  logic          poll_go;
  logic [7:0]    poll_addr;
  op_e           poll_op;

  assign cmd    = pend_q[7:0];
  assign cadr   = pend_q[15:8];
  assign adr_ok = {1'b0, cadr} < ADDR_LIM;
`ifdef SENSOR_CMD_CONTINUOUS_EN
  assign cmd_ok = cmd <= 8'h06;

  typedef enum logic [1:0] {MODE_OFF, MODE_TEMP, MODE_HUM} mode_e;
  localparam int unsigned   PW       = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);

  mode_e         mode_q, mode_d;
  logic [7:0]    maddr_q, maddr_d;
  logic [PW-1:0] ptmr_q, ptmr_d;
  logic          pdue_q, pdue_d;
  logic          en_t, en_h, dis_t, dis_h, poll_start;

  // Order matters: timer tick, then poll start, then enable/disable overrides.
  always_comb begin
    mode_d  = mode_q;
    maddr_d = maddr_q;
    ptmr_d  = ptmr_q;
    pdue_d  = pdue_q;
    if (mode_q != MODE_OFF) begin
      if (ptmr_q == PER_LAST) begin
        ptmr_d = '0;
        pdue_d = 1'b1;
      end else begin
        ptmr_d = ptmr_q + PW'(1);
      end
    end
    if (poll_start) pdue_d = 1'b0;
    if (en_t || en_h) begin
      mode_d  = en_t ? MODE_TEMP : MODE_HUM;
      maddr_d = cadr;
      ptmr_d  = '0;
      pdue_d  = 1'b0;
    end
    if ((dis_t && mode_q == MODE_TEMP) || (dis_h && mode_q == MODE_HUM)) begin
      mode_d = MODE_OFF;
      ptmr_d = '0;
      pdue_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_OFF;
      maddr_q <= '0;
      ptmr_q  <= '0;
      pdue_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      maddr_q <= maddr_d;
      ptmr_q  <= ptmr_d;
      pdue_q  <= pdue_d;
    end
  end

  assign poll_go   = pdue_q && (mode_q != MODE_OFF);
  assign poll_addr = maddr_q;
  assign poll_op   = (mode_q == MODE_HUM) ? OP_CHUM : OP_CTEMP;
`else
  assign cmd_ok    = cmd <= 8'h02;
  assign poll_go   = 1'b0;
  assign poll_addr = '0;
  assign poll_op   = OP_CTEMP;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    tcnt_d     = tcnt_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
`ifdef SENSOR_CMD_CONTINUOUS_EN
    en_t       = 1'b0;
    en_h       = 1'b0;
    dis_t      = 1'b0;
    dis_h      = 1'b0;
    poll_start = 1'b0;
`endif
    // A frame arriving while the buffer is still occupied is dropped.
    if (state_q == IDLE && pend_vld_q) pend_vld_d = 1'b0;
    if (rise_q && !pend_vld_q) begin
      pend_vld_d = 1'b1;
      pend_d     = rx_data;
    end
    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          if (!cmd_ok) begin
            state_d = SEND;
            tx_d    = {cmd, 8'hE0};
          end else if (!adr_ok) begin
            state_d = SEND;
            tx_d    = {cadr, 8'hE1};
          end else begin
            state_d = SENSOR;
            addr_d  = cadr;
            tcnt_d  = '0;
            case (cmd)
              8'h00: op_d = OP_STATUS;
              8'h01: op_d = OP_TEMP;
              8'h02: op_d = OP_HUM;
`ifdef SENSOR_CMD_CONTINUOUS_EN
              8'h03: begin op_d = OP_CTEMP; en_t = 1'b1; end
              8'h04: begin op_d = OP_CHUM;  en_h = 1'b1; end
              8'h05: begin state_d = SEND; tx_d = {cadr, 8'h0A}; dis_t = 1'b1; end
              8'h06: begin state_d = SEND; tx_d = {cadr, 8'h0B}; dis_h = 1'b1; end
`endif
              default: op_d = op_q;
            endcase
          end
        end else if (poll_go) begin
          state_d = SENSOR;
          op_d    = poll_op;
          addr_d  = poll_addr;
          tcnt_d  = '0;
`ifdef SENSOR_CMD_CONTINUOUS_EN
          poll_start = 1'b1;
`endif
        end
      end
      SENSOR: begin
        tcnt_d = tcnt_q + TW'(1);
        if (sns_done) begin
          state_d = SEND;
          if (!sns_ok) tx_d = {addr_q, 8'h1F};
          else begin
            case (op_q)
              OP_STATUS: tx_d = {addr_q, 8'h07};
              OP_TEMP:   tx_d = {sns_temp, 8'h09};
              OP_HUM:    tx_d = {sns_hum, 8'h08};
              OP_CTEMP:  tx_d = {sns_temp, 8'h0C};
              default:   tx_d = {sns_hum, 8'h0D};
            endcase
          end
        end else if (tcnt_q == TO_LAST) begin
          state_d = SEND;
          tx_d    = {addr_q, 8'h1F};
        end
      end
      SEND: if (tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_STATUS;
      addr_q     <= '0;
      tx_q       <= '0;
      tcnt_q     <= '0;
      sync_q     <= '0;
      rise_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      tcnt_q     <= tcnt_d;
      sync_q     <= {sync_q[1:0], rx_recived};
      rise_q     <= sync_q[1] & ~sync_q[2];
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
    end
  end

  assign sns_req   = (state_q == SENSOR);
  assign tx_valid  = (state_q == SEND);
  assign sns_addr  = addr_q;
  assign tx_data   = tx_q;
  assign state_out = state_q;
endmodule

// File: tb/tb_sensor_cmd_decoder.sv
// Bench for sensor_cmd_decoder: directed vector table, multi-cycle corner sequences and randomized frames vs a rule model.
`timescale 1ns/1ps
module tb_sensor_cmd_decoder;
  localparam int unsigned NS  = 32;
  localparam int unsigned TO  = 40;
  localparam int unsigned PER = 100;
`ifdef SENSOR_CMD_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_recived = 1'b0;
  logic        sns_req;
  logic [7:0]  sns_addr;
  logic        sns_done = 1'b0;
  logic        sns_ok = 1'b0;
  logic [7:0]  sns_temp = '0;
  logic [7:0]  sns_hum = '0;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready = 1'b0;
  logic [1:0]  state_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sensor_cmd_decoder #(
    .NUM_SENSORS(NS),
    .TIMEOUT_CYCLES(TO),
    .PERIOD_CYCLES(PER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_recived(rx_recived),
    .sns_req(sns_req), .sns_addr(sns_addr), .sns_done(sns_done), .sns_ok(sns_ok),
    .sns_temp(sns_temp), .sns_hum(sns_hum), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .state_out(state_out)
  );

  typedef struct {
    logic [15:0] f;
    bit          ok;
    int          delay;
    logic [7:0]  t;
    logic [7:0]  h;
    logic        exp_req;
    logic [15:0] exp_tx;
  } vec_t;
  vec_t vt[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Response rules: command validity, then address range, then disable, then sensor outcome.
  function automatic void model(input logic [15:0] f, input bit ok, input bit to,
                                input logic [7:0] t, input logic [7:0] h,
                                output logic req, output logic [15:0] resp);
    int c;
    int a;
    int max_cmd;
    c = int'(f[7:0]);
    a = int'(f[15:8]);
    max_cmd = CONT ? 6 : 2;
    req = 1'b0;
    if (c > max_cmd) resp = {f[7:0], 8'hE0};
    else if (a >= int'(NS)) resp = {f[15:8], 8'hE1};
    else if (c == 5) resp = {f[15:8], 8'h0A};
    else if (c == 6) resp = {f[15:8], 8'h0B};
    else begin
      req = 1'b1;
      if (!ok || to) resp = {f[15:8], 8'h1F};
      else if (c == 0) resp = {f[15:8], 8'h07};
      else if (c == 1) resp = {t, 8'h09};
      else if (c == 2) resp = {h, 8'h08};
      else if (c == 3) resp = {t, 8'h0C};
      else resp = {h, 8'h0D};
    end
  endfunction

  task automatic wait_resp(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sns_req || tx_valid) && n < 20);
  endtask

  task automatic pulse_done(input bit ok, input logic [7:0] t, input logic [7:0] h);
    sns_done = 1'b1; sns_ok = ok; sns_temp = t; sns_hum = h;
    @(negedge clk);
    sns_done = 1'b0; sns_ok = 1'b0;
  endtask

  task automatic handshake(input string nm);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check({nm, " release"}, {30'b0, tx_valid, 1'b0} | {30'b0, state_out}, 32'd0);
  endtask

  task automatic send_frame(input logic [15:0] f);
    @(posedge clk); #1 rx_data = f; rx_recived = 1'b1;
    repeat (5) @(posedge clk);
    #1 rx_recived = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  // delay < 0: the sensor never answers; otherwise sns_done after 'delay' SENSOR cycles.
  task automatic run_vec(input string nm, input logic [15:0] f, input bit ok, input int delay,
                         input logic [7:0] t, input logic [7:0] h,
                         input logic exp_req, input logic [15:0] exp_tx);
    int n;
    int nreq;
    @(posedge clk); #1 rx_data = f; rx_recived = 1'b1;
    wait_resp(n);
    check({nm, " latency"}, n, 6);
    check({nm, " req"}, {31'b0, sns_req}, {31'b0, exp_req});
    rx_recived = 1'b0;
    if (sns_req) begin
      check({nm, " addr"}, {24'b0, sns_addr}, {24'b0, f[15:8]});
      if (delay >= 0) begin
        repeat (delay) @(negedge clk);
        pulse_done(ok, t, h);
        check({nm, " req drop"}, {31'b0, sns_req}, 32'd0);
      end else begin
        nreq = 1;
        while (sns_req && nreq < int'(TO) + 10) begin
          @(negedge clk);
          if (sns_req) nreq++;
        end
        check({nm, " timeout len"}, nreq, TO);
      end
    end
    check({nm, " valid"}, {31'b0, tx_valid}, 32'd1);
    check({nm, " data"}, {16'b0, tx_data}, {16'b0, exp_tx});
    repeat (2) @(negedge clk);
    check({nm, " data held"}, {15'b0, tx_valid, tx_data}, {15'b0, 1'b1, exp_tx});
    handshake(nm);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no summary by time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy;
    int tpoll[3];

    vt[0] = '{16'h0501, 1'b1, 2,      8'h19, 8'h00, 1'b1, 16'h1909};
    vt[1] = '{16'h0007, 1'b1, 0,      8'h00, 8'h00, 1'b0, 16'h07E0};
    vt[2] = '{16'h2802, 1'b1, 0,      8'h00, 8'h00, 1'b0, 16'h28E1};
    vt[3] = '{16'h0300, 1'b1, -1,     8'h00, 8'h00, 1'b1, 16'h031F};
    vt[4] = '{16'h0400, 1'b1, TO - 1, 8'h00, 8'h00, 1'b1, 16'h0407};
    vt[5] = '{16'h1F02, 1'b1, 0,      8'h00, 8'h33, 1'b1, 16'h3308};
    vt[6] = '{16'h2000, 1'b1, 0,      8'h00, 8'h00, 1'b0, 16'h20E1};
    vt[7] = '{16'h40FF, 1'b1, 0,      8'h00, 8'h00, 1'b0, 16'hFFE0};
    vt[8] = '{16'h0A01, 1'b0, 3,      8'h55, 8'h00, 1'b1, 16'h0A1F};
    vt[9] = '{16'h1E01, 1'b1, 1,      8'hA5, 8'h00, 1'b1, 16'hA509};
`ifdef SENSOR_CMD_CONTINUOUS_EN
    vt[10] = '{16'h0206, 1'b1, 0, 8'h00, 8'h00, 1'b0, 16'h020B};
    vt[11] = '{16'h0105, 1'b1, 0, 8'h00, 8'h00, 1'b0, 16'h010A};
    vt[12] = '{16'h2005, 1'b1, 0, 8'h00, 8'h00, 1'b0, 16'h20E1};
`else
    vt[10] = '{16'h0204, 1'b1, 0, 8'h00, 8'h00, 1'b0, 16'h04E0};
    vt[11] = '{16'h0206, 1'b1, 0, 8'h00, 8'h00, 1'b0, 16'h06E0};
    vt[12] = '{16'h0003, 1'b1, 0, 8'h00, 8'h00, 1'b0, 16'h03E0};
`endif

    repeat (3) @(negedge clk);
    check("reset outputs", {4'b0, sns_req, tx_valid, state_out, sns_addr, tx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post-release idle", {4'b0, sns_req, tx_valid, state_out, sns_addr, tx_data}, 32'd0);

    for (int i = 0; i < 13; i++)
      run_vec($sformatf("vec%0d", i), vt[i].f, vt[i].ok, vt[i].delay, vt[i].t, vt[i].h,
              vt[i].exp_req, vt[i].exp_tx);

    for (int i = 0; i < 40; i++) begin
      logic [7:0]  c;
      logic [7:0]  a;
      bit          ok;
      int          d;
      logic [7:0]  t;
      logic [7:0]  h;
      logic        er;
      logic [15:0] ex;
      c = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      if (CONT && (c == 8'h03 || c == 8'h04)) c = 8'h01;
      a = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 40)) : 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 6));
      t = 8'($urandom);
      h = 8'($urandom);
      model({a, c}, ok, d < 0, t, h, er, ex);
      run_vec($sformatf("rnd%0d", i), {a, c}, ok, d, t, h, er, ex);
    end

    // Three frames while the first response is stalled: second queues, third is lost.
    tx_ready = 1'b0;
    send_frame(16'h0007);
    send_frame(16'h0301);
    send_frame(16'h0402);
    @(negedge clk);
    busy = 0;
    repeat (10) begin
      if (tx_data !== 16'h07E0 || !tx_valid) busy++;
      @(negedge clk);
    end
    check("b2b first held", busy, 0);
    handshake("b2b first");
    wait_resp(n);
    check("b2b second req", {31'b0, sns_req}, 32'd1);
    check("b2b second addr", {24'b0, sns_addr}, 32'd3);
    @(negedge clk);
    pulse_done(1'b1, 8'h77, 8'h00);
    check("b2b second data", {15'b0, tx_valid, tx_data}, {15'b0, 1'b1, 16'h7709});
    handshake("b2b second");
    busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (sns_req || tx_valid) busy++;
    end
    check("b2b third lost", busy, 0);

`ifdef SENSOR_CMD_CONTINUOUS_EN
    @(posedge clk); #1 rx_data = 16'h0204; rx_recived = 1'b1;
    wait_resp(n);
    check("cont enable latency", n, 6);
    check("cont enable req", {31'b0, sns_req}, 32'd1);
    check("cont enable addr", {24'b0, sns_addr}, 32'd2);
    rx_recived = 1'b0;
    pulse_done(1'b1, 8'h00, 8'h41);
    check("cont enable data", {15'b0, tx_valid, tx_data}, {15'b0, 1'b1, 16'h410D});
    handshake("cont enable");
    for (int p = 0; p < 3; p++) begin
      n = 0;
      while (!sns_req && n < int'(PER) + 20) begin
        @(negedge clk);
        n++;
      end
      tpoll[p] = cyc;
      check($sformatf("poll%0d req", p), {31'b0, sns_req}, 32'd1);
      check($sformatf("poll%0d addr", p), {24'b0, sns_addr}, 32'd2);
      @(negedge clk);
      pulse_done(1'b1, 8'h00, 8'(8'h50 + p));
      check($sformatf("poll%0d data", p), {15'b0, tx_valid, tx_data},
            {15'b0, 1'b1, 8'(8'h50 + p), 8'h0D});
      handshake($sformatf("poll%0d", p));
    end
    check("poll interval 1", tpoll[1] - tpoll[0], PER);
    check("poll interval 2", tpoll[2] - tpoll[1], PER);
    run_vec("cont disable", 16'h0206, 1'b1, 0, 8'h00, 8'h00, 1'b0, 16'h020B);
    busy = 0;
    repeat (3 * PER) begin
      @(negedge clk);
      if (sns_req) busy++;
    end
    check("polling stopped", busy, 0);
`endif

    @(posedge clk); #1 rx_data = 16'h0501; rx_recived = 1'b1;
    wait_resp(n);
    check("rst in sensor req", {31'b0, sns_req}, 32'd1);
    rx_recived = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst in sensor outputs", {4'b0, sns_req, tx_valid, state_out, sns_addr, tx_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (sns_req || tx_valid) busy++;
    end
    check("rst in sensor quiet", busy, 0);
    run_vec("after rst sensor", 16'h0601, 1'b1, 1, 8'h2A, 8'h00, 1'b1, 16'h2A09);

    @(posedge clk); #1 rx_data = 16'h0007; rx_recived = 1'b1;
    wait_resp(n);
    check("rst in send valid", {31'b0, tx_valid}, 32'd1);
    rx_recived = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1 check("rst in send outputs", {4'b0, sns_req, tx_valid, state_out, sns_addr, tx_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (sns_req || tx_valid) busy++;
    end
    check("rst in send quiet", busy, 0);
    run_vec("after rst send", 16'h0102, 1'b1, 0, 8'h00, 8'h11, 1'b1, 16'h1108);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
